// File: rtl/shell_pkg.sv
// Shared constants and types for the shell scheduler: direction codes, grid limits and the
// per-channel state encoding.
package shell_pkg;

  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_DOWN  = 2'b01;
  localparam logic [1:0] DIR_LEFT  = 2'b10;
  localparam logic [1:0] DIR_RIGHT = 2'b11;

  localparam int unsigned      POS_W       = 5;
  localparam logic [POS_W-1:0] POS_INVALID = 5'b11111;
  localparam logic [POS_W-1:0] GRID_X_MAX  = 5'd24;
  localparam logic [POS_W-1:0] GRID_Y_MAX  = 5'd12;

  typedef enum logic {
    FREE,
    FLYING
  } ch_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first request at or above ptr,
// wrapping at N.
module rr_arbiter #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         gnt
);

  logic        found;
  int unsigned idx;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = 0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = (32'(ptr) + i) % N;
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/shell_scheduler.sv
// Binds a small pool of shell channels to tank fire requests, one grant per clk, round-robin
// between tanks, with one shell per tank in flight and a post-release cooldown.
module shell_scheduler
  import shell_pkg::*;
#(
  parameter int unsigned NREQ       = 4,
  parameter int unsigned NCH        = 2,
  parameter int unsigned COOLDOWN   = 2,
  parameter int unsigned MAX_FLIGHT = 31
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        enable,
  input  logic                        tick,
  input  logic [NREQ-1:0]             fire_req,
  input  logic [2*NREQ-1:0]           fire_dir,
  input  logic [POS_W*NREQ-1:0]       tank_xpos,
  input  logic [POS_W*NREQ-1:0]       tank_ypos,
  input  logic [NCH-1:0]              ch_done,
  output logic [NCH-1:0]              ch_active,
  output logic [2*NCH-1:0]            ch_dir,
  output logic [POS_W*NCH-1:0]        ch_xpos,
  output logic [POS_W*NCH-1:0]        ch_ypos,
  output logic [$clog2(NREQ)*NCH-1:0] ch_owner,
  output logic [NREQ-1:0]             fire_ack,
  output logic [NREQ-1:0]             fire_busy
);

  localparam int unsigned OW = $clog2(NREQ);
  localparam int unsigned FW = $clog2(MAX_FLIGHT + 1);
  localparam int unsigned CW = $clog2(COOLDOWN + 1);

  ch_state_e        state_q  [NCH];
  ch_state_e        state_d  [NCH];
  logic [FW-1:0]    flight_q [NCH];
  logic [FW-1:0]    flight_d [NCH];
  logic [1:0]       dir_q    [NCH];
  logic [1:0]       dir_d    [NCH];
  logic [POS_W-1:0] xpos_q   [NCH];
  logic [POS_W-1:0] xpos_d   [NCH];
  logic [POS_W-1:0] ypos_q   [NCH];
  logic [POS_W-1:0] ypos_d   [NCH];
  logic [OW-1:0]    owner_q  [NCH];
  logic [OW-1:0]    owner_d  [NCH];
  logic [CW-1:0]    cool_q   [NREQ];
  logic [CW-1:0]    cool_d   [NREQ];
  logic [NREQ-1:0]  inflight_q, inflight_d;
  logic [NREQ-1:0]  ack_q, ack_d;
  logic [NREQ-1:0]  busy_q, busy_d;
  logic [OW-1:0]    rr_q, rr_d;

  logic [NREQ-1:0]  elig;
  logic [NREQ-1:0]  win_oh;
  logic             any_free;
  logic             any_win;
  int unsigned      free_idx;
  int unsigned      win_idx;
  logic [FW-1:0]    fl_next;
  logic             timeout;

  always_comb begin
    elig = '0;
    for (int unsigned r = 0; r < NREQ; r++) begin
      elig[r] = enable && fire_req[r] && !inflight_q[r] && (cool_q[r] == '0) &&
                (tank_xpos[POS_W*r +: POS_W] <= GRID_X_MAX) &&
                (tank_ypos[POS_W*r +: POS_W] <= GRID_Y_MAX);
    end
  end

  rr_arbiter #(
    .N (NREQ)
  ) u_rr_arbiter (
    .req (elig),
    .ptr (rr_q),
    .gnt (win_oh)
  );

  always_comb begin
    state_d    = state_q;
    flight_d   = flight_q;
    dir_d      = dir_q;
    xpos_d     = xpos_q;
    ypos_d     = ypos_q;
    owner_d    = owner_q;
    cool_d     = cool_q;
    inflight_d = inflight_q;
    rr_d       = rr_q;
    ack_d      = '0;
    busy_d     = '0;
    any_free   = 1'b0;
    free_idx   = 0;
    any_win    = |win_oh;
    win_idx    = 0;
    fl_next    = '0;
    timeout    = 1'b0;

    // Channels releasing this cycle are still FLYING here, so they never count as free.
    for (int unsigned c = 0; c < NCH; c++) begin
      if (!any_free && state_q[c] == FREE) begin
        any_free = 1'b1;
        free_idx = c;
      end
    end
    for (int unsigned r = 0; r < NREQ; r++) begin
      if (win_oh[r]) win_idx = r;
    end

    if (enable) begin
      for (int unsigned r = 0; r < NREQ; r++) begin
        if (tick && cool_q[r] != '0) cool_d[r] = cool_q[r] - 1'b1;
      end

      // A release re-arms the owner's cooldown, overriding any decrement above.
      for (int unsigned c = 0; c < NCH; c++) begin
        if (state_q[c] == FLYING) begin
          fl_next = flight_q[c];
          timeout = 1'b0;
          if (tick) begin
            if (flight_q[c] != FW'(MAX_FLIGHT)) fl_next = flight_q[c] + 1'b1;
            timeout = (fl_next == FW'(MAX_FLIGHT));
          end
          flight_d[c] = fl_next;
          if (ch_done[c] || timeout) begin
            state_d[c]             = FREE;
            inflight_d[owner_q[c]] = 1'b0;
            cool_d[owner_q[c]]     = CW'(COOLDOWN);
          end
        end
      end

      if (any_win && any_free) begin
        state_d[free_idx]   = FLYING;
        flight_d[free_idx]  = '0;
        dir_d[free_idx]     = fire_dir[2*win_idx +: 2];
        xpos_d[free_idx]    = tank_xpos[POS_W*win_idx +: POS_W];
        ypos_d[free_idx]    = tank_ypos[POS_W*win_idx +: POS_W];
        owner_d[free_idx]   = OW'(win_idx);
        inflight_d[win_idx] = 1'b1;
        ack_d[win_idx]      = 1'b1;
        rr_d                = OW'((win_idx + 1) % NREQ);
      end else if (!any_free) begin
        busy_d = elig;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned c = 0; c < NCH; c++) begin
        state_q[c]  <= FREE;
        flight_q[c] <= '0;
        dir_q[c]    <= '0;
        xpos_q[c]   <= '0;
        ypos_q[c]   <= '0;
        owner_q[c]  <= '0;
      end
      for (int unsigned r = 0; r < NREQ; r++) begin
        cool_q[r] <= '0;
      end
      inflight_q <= '0;
      ack_q      <= '0;
      busy_q     <= '0;
      rr_q       <= '0;
    end else begin
      state_q    <= state_d;
      flight_q   <= flight_d;
      dir_q      <= dir_d;
      xpos_q     <= xpos_d;
      ypos_q     <= ypos_d;
      owner_q    <= owner_d;
      cool_q     <= cool_d;
      inflight_q <= inflight_d;
      ack_q      <= ack_d;
      busy_q     <= busy_d;
      rr_q       <= rr_d;
    end
  end

  always_comb begin
    ch_active = '0;
    ch_dir    = '0;
    ch_xpos   = '0;
    ch_ypos   = '0;
    ch_owner  = '0;
    for (int unsigned c = 0; c < NCH; c++) begin
      ch_active[c]             = (state_q[c] == FLYING);
      ch_dir[2*c +: 2]         = dir_q[c];
      ch_xpos[POS_W*c +: POS_W] = xpos_q[c];
      ch_ypos[POS_W*c +: POS_W] = ypos_q[c];
      ch_owner[OW*c +: OW]     = owner_q[c];
    end
  end

  assign fire_ack  = ack_q;
  assign fire_busy = busy_q;

endmodule

// File: tb/tb_shell_scheduler.sv
// Bench for shell_scheduler: directed scenarios plus random traffic, all checked against a
// cycle-level reference model of the channel pool kept in the bench.
module tb_shell_scheduler;

  localparam int NREQ       = 4;
  localparam int NCH        = 2;
  localparam int COOLDOWN   = 2;
  localparam int MAX_FLIGHT = 31;

  logic                clk       = 1'b0;
  logic                rst_n     = 1'b0;
  logic                enable    = 1'b0;
  logic                tick      = 1'b0;
  logic [NREQ-1:0]     fire_req  = '0;
  logic [2*NREQ-1:0]   fire_dir  = '0;
  logic [5*NREQ-1:0]   tank_xpos = '0;
  logic [5*NREQ-1:0]   tank_ypos = '0;
  logic [NCH-1:0]      ch_done   = '0;
  logic [NCH-1:0]      ch_active;
  logic [2*NCH-1:0]    ch_dir;
  logic [5*NCH-1:0]    ch_xpos;
  logic [5*NCH-1:0]    ch_ypos;
  logic [2*NCH-1:0]    ch_owner;
  logic [NREQ-1:0]     fire_ack;
  logic [NREQ-1:0]     fire_busy;

  int    checks   = 0;
  int    failures = 0;
  string cur_test = "init";

  // Reference model state
  bit         m_act  [NCH];
  int         m_age  [NCH];
  logic [1:0] m_own  [NCH];
  logic [1:0] m_dir  [NCH];
  logic [4:0] m_x    [NCH];
  logic [4:0] m_y    [NCH];
  bit         m_infl [NREQ];
  int         m_cool [NREQ];
  int         m_rr;
  logic [NREQ-1:0] m_ack, m_fb;

  shell_scheduler #(
    .NREQ       (NREQ),
    .NCH        (NCH),
    .COOLDOWN   (COOLDOWN),
    .MAX_FLIGHT (MAX_FLIGHT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .tick      (tick),
    .fire_req  (fire_req),
    .fire_dir  (fire_dir),
    .tank_xpos (tank_xpos),
    .tank_ypos (tank_ypos),
    .ch_done   (ch_done),
    .ch_active (ch_active),
    .ch_dir    (ch_dir),
    .ch_xpos   (ch_xpos),
    .ch_ypos   (ch_ypos),
    .ch_owner  (ch_owner),
    .fire_ack  (fire_ack),
    .fire_busy (fire_busy)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_act[c] = 0; m_age[c] = 0; m_own[c] = '0; m_dir[c] = '0; m_x[c] = '0; m_y[c] = '0;
    end
    for (int r = 0; r < NREQ; r++) begin
      m_infl[r] = 0; m_cool[r] = 0;
    end
    m_rr = 0; m_ack = '0; m_fb = '0;
  endtask

  task automatic set_tank(input int r, input logic [1:0] d, input logic [4:0] x,
                          input logic [4:0] y);
    fire_dir[2*r +: 2]  = d;
    tank_xpos[5*r +: 5] = x;
    tank_ypos[5*r +: 5] = y;
  endtask

  // Advance one clk: predict from current inputs, clock the DUT, compare 1 ns after the edge.
  task automatic step();
    logic [NREQ-1:0]  elig;
    logic [NCH-1:0]   e_act;
    logic [2*NCH-1:0] e_dir, e_own;
    logic [5*NCH-1:0] e_x, e_y;
    int win, fc, r;
    elig = '0; win = -1; fc = -1; m_ack = '0; m_fb = '0;
    if (enable) begin
      for (int i = 0; i < NREQ; i++)
        elig[i] = fire_req[i] && !m_infl[i] && m_cool[i] == 0 &&
                  tank_xpos[5*i +: 5] <= 24 && tank_ypos[5*i +: 5] <= 12;
      for (int k = 0; k < NREQ; k++) begin
        r = (m_rr + k) % NREQ;
        if (win < 0 && elig[r]) win = r;
      end
      for (int c = 0; c < NCH; c++) if (fc < 0 && !m_act[c]) fc = c;
      for (int i = 0; i < NREQ; i++) if (tick && m_cool[i] > 0) m_cool[i]--;
      for (int c = 0; c < NCH; c++) begin
        if (m_act[c]) begin
          if (tick && m_age[c] < MAX_FLIGHT) m_age[c]++;
          if (ch_done[c] || (tick && m_age[c] == MAX_FLIGHT)) begin
            m_act[c] = 0;
            m_infl[m_own[c]] = 0;
            m_cool[m_own[c]] = COOLDOWN;
          end
        end
      end
      if (win >= 0 && fc >= 0) begin
        m_act[fc] = 1; m_age[fc] = 0; m_own[fc] = 2'(win);
        m_dir[fc] = fire_dir[2*win +: 2];
        m_x[fc] = tank_xpos[5*win +: 5];
        m_y[fc] = tank_ypos[5*win +: 5];
        m_infl[win] = 1; m_ack[win] = 1'b1; m_rr = (win + 1) % NREQ;
      end else if (fc < 0) begin
        m_fb = elig;
      end
    end
    @(posedge clk);
    #1;
    for (int c = 0; c < NCH; c++) begin
      e_act[c] = m_act[c]; e_dir[2*c +: 2] = m_dir[c]; e_own[2*c +: 2] = m_own[c];
      e_x[5*c +: 5] = m_x[c]; e_y[5*c +: 5] = m_y[c];
    end
    checks++;
    if (fire_ack !== m_ack) begin
      failures++;
      $display("FAIL %s ack: got %b want %b", cur_test, fire_ack, m_ack);
    end
    checks++;
    if (fire_busy !== m_fb) begin
      failures++;
      $display("FAIL %s busy: got %b want %b", cur_test, fire_busy, m_fb);
    end
    checks++;
    if ({ch_active, ch_dir, ch_xpos, ch_ypos, ch_owner} !== {e_act, e_dir, e_x, e_y, e_own}) begin
      failures++;
      $display("FAIL %s chan: got act=%b dir=%h x=%h y=%h own=%h want act=%b dir=%h x=%h y=%h own=%h",
               cur_test, ch_active, ch_dir, ch_xpos, ch_ypos, ch_owner,
               e_act, e_dir, e_x, e_y, e_own);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; enable = 1'b1; tick = 1'b0; fire_req = '0; ch_done = '0;
    fire_dir = '0; tank_xpos = '0; tank_ypos = '0;
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    cur_test = "reset";
    rst_n = 1'b0;
    #3;
    checks++;
    if ({ch_active, ch_dir, ch_xpos, ch_ypos, ch_owner, fire_ack, fire_busy} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got act=%b ack=%b busy=%b want all zero",
               ch_active, fire_ack, fire_busy);
    end
    do_reset();
    set_tank(0, 2'b01, 5'd7, 5'd3);
    fire_req = 4'b0001;
    step();
    fire_req = 4'b0000;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({ch_active, fire_ack, fire_busy} !== '0) begin
      failures++;
      $display("FAIL reset_midflight: got act=%b ack=%b busy=%b want 0",
               ch_active, fire_ack, fire_busy);
    end
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    set_tank(1, 2'b10, 5'd10, 5'd11);
    fire_req = 4'b0010;
    step();
    checks++;
    if (ch_active !== 2'b01 || ch_owner[1:0] !== 2'd1 || fire_ack !== 4'b0010) begin
      failures++;
      $display("FAIL reset_regrant: got act=%b own0=%0d ack=%b want act=01 own0=1 ack=0010",
               ch_active, ch_owner[1:0], fire_ack);
    end
  endtask

  task automatic test_fire_basic();
    cur_test = "fire_basic";
    do_reset();
    set_tank(0, 2'b11, 5'd3, 5'd5);
    fire_req = 4'b0001;
    step();
    checks++;
    if (ch_active !== 2'b01 || ch_owner[1:0] !== 2'd0 || ch_xpos[4:0] !== 5'd3 ||
        ch_ypos[4:0] !== 5'd5 || ch_dir[1:0] !== 2'b11 || fire_ack !== 4'b0001) begin
      failures++;
      $display("FAIL fire_basic: got act=%b own0=%0d x0=%0d y0=%0d dir0=%b ack=%b want 01 0 3 5 11 0001",
               ch_active, ch_owner[1:0], ch_xpos[4:0], ch_ypos[4:0], ch_dir[1:0], fire_ack);
    end
    fire_req = 4'b0000;
    step();
    checks++;
    if (fire_ack !== 4'b0000 || ch_active !== 2'b01) begin
      failures++;
      $display("FAIL ack_one_cycle: got ack=%b act=%b want 0000 01", fire_ack, ch_active);
    end
  endtask

  task automatic test_all_request();
    cur_test = "all_request";
    do_reset();
    for (int r = 0; r < NREQ; r++) set_tank(r, 2'(r), 5'(r + 1), 5'(r + 2));
    fire_req = 4'b1111;
    step();
    fire_req[0] = 1'b0;
    step();
    checks++;
    if (fire_ack !== 4'b0010 || ch_active !== 2'b11 || ch_owner !== 4'b0100) begin
      failures++;
      $display("FAIL all_second: got ack=%b act=%b own=%b want 0010 11 0100",
               fire_ack, ch_active, ch_owner);
    end
    fire_req[1] = 1'b0;
    step();
    checks++;
    if (fire_busy !== 4'b1100) begin
      failures++;
      $display("FAIL all_busy: got %b want 1100", fire_busy);
    end
    ch_done = 2'b01;
    step();
    ch_done = 2'b00;
    step();
    checks++;
    if (fire_ack !== 4'b0100 || ch_owner[1:0] !== 2'd2) begin
      failures++;
      $display("FAIL all_regrant: got ack=%b own0=%0d want 0100 2", fire_ack, ch_owner[1:0]);
    end
  endtask

  task automatic test_cooldown();
    logic [NREQ-1:0] acks;
    cur_test = "cooldown";
    do_reset();
    set_tank(0, 2'b00, 5'd24, 5'd12);
    fire_req = 4'b0001;
    step();
    ch_done = 2'b01;
    step();
    ch_done = 2'b00;
    acks = '0;
    tick = 1'b1; step(); acks |= fire_ack;
    tick = 1'b0; step(); acks |= fire_ack;
    tick = 1'b1; step(); acks |= fire_ack;
    tick = 1'b0;
    checks++;
    if (acks !== 4'b0000) begin
      failures++;
      $display("FAIL cooldown_hold: got ack_seen=%b want 0000", acks);
    end
    step();
    checks++;
    if (fire_ack !== 4'b0001) begin
      failures++;
      $display("FAIL cooldown_grant: got %b want 0001", fire_ack);
    end
    fire_req = '0;
  endtask

  task automatic test_timeout();
    cur_test = "timeout";
    do_reset();
    set_tank(3, 2'b10, 5'd20, 5'd1);
    fire_req = 4'b1000;
    step();
    fire_req = '0;
    tick = 1'b1;
    for (int i = 0; i < 30; i++) step();
    checks++;
    if (ch_active !== 2'b01) begin
      failures++;
      $display("FAIL timeout_before: got act=%b want 01", ch_active);
    end
    step();
    checks++;
    if (ch_active !== 2'b00) begin
      failures++;
      $display("FAIL timeout_release: got act=%b want 00", ch_active);
    end
    tick = 1'b0;
    fire_req = 4'b1000;
    step();
    step();
    checks++;
    if (fire_ack !== 4'b0000) begin
      failures++;
      $display("FAIL timeout_cooldown: got ack=%b want 0000", fire_ack);
    end
    tick = 1'b1;
    for (int i = 0; i < 4; i++) step();
    tick = 1'b0;
    fire_req = '0;
  endtask

  task automatic test_collision_enable();
    cur_test = "collision";
    do_reset();
    set_tank(0, 2'b01, 5'd2, 5'd2);
    set_tank(1, 2'b11, 5'd9, 5'd4);
    set_tank(2, 2'b10, 5'd15, 5'd8);
    fire_req = 4'b0101;
    step();
    fire_req[0] = 1'b0;
    step();
    fire_req[2] = 1'b0;
    ch_done = 2'b01;
    fire_req[1] = 1'b1;
    step();
    checks++;
    if (fire_ack !== 4'b0000 || fire_busy !== 4'b0010) begin
      failures++;
      $display("FAIL collide_same_cycle: got ack=%b busy=%b want 0000 0010", fire_ack, fire_busy);
    end
    ch_done = 2'b00;
    step();
    checks++;
    if (fire_ack !== 4'b0010 || ch_owner[1:0] !== 2'd1) begin
      failures++;
      $display("FAIL collide_next: got ack=%b own0=%0d want 0010 1", fire_ack, ch_owner[1:0]);
    end
    fire_req = 4'b0001;
    cur_test = "freeze";
    enable = 1'b0;
    tick = 1'b1;
    for (int i = 0; i < 10; i++) begin
      ch_done = (i % 3 == 0) ? 2'b11 : 2'b00;
      step();
    end
    ch_done = 2'b00;
    checks++;
    if (ch_active !== 2'b11 || fire_ack !== '0 || fire_busy !== '0) begin
      failures++;
      $display("FAIL freeze_hold: got act=%b ack=%b busy=%b want 11 0000 0000",
               ch_active, fire_ack, fire_busy);
    end
    enable = 1'b1;
    for (int i = 0; i < 40; i++) step();
    tick = 1'b0;
    fire_req = '0;
  endtask

  task automatic test_random();
    cur_test = "random";
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      enable  = ($urandom_range(0, 19) != 0);
      tick    = ($urandom_range(0, 2) == 0);
      ch_done = '0;
      for (int c = 0; c < NCH; c++) ch_done[c] = ($urandom_range(0, 11) == 0);
      for (int r = 0; r < NREQ; r++) begin
        if (!fire_req[r] && $urandom_range(0, 3) == 0) begin
          fire_req[r] = 1'b1;
          if ($urandom_range(0, 7) == 0)
            set_tank(r, 2'($urandom), 5'b11111, 5'($urandom_range(0, 12)));
          else
            set_tank(r, 2'($urandom), 5'($urandom_range(0, 26)), 5'($urandom_range(0, 14)));
        end else if (fire_req[r] && $urandom_range(0, 15) == 0) begin
          fire_req[r] = 1'b0;
        end
      end
      step();
      fire_req = fire_req & ~m_ack;
    end
    enable = 1'b1; tick = 1'b0; ch_done = '0; fire_req = '0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_fire_basic();
    test_all_request();
    test_cooldown();
    test_timeout();
    test_collision_enable();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
